// File: rtl/pipe_control.sv
// Pipelined control unit for the 16-bit myMIPS core: decodes the ID word and carries a
// control bundle through ID/EX, EX/MEM and MEM/WB, with load-use stall and transfer flush.
module pipe_control #(
  parameter int unsigned       REG_AW       = 4,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter logic [REG_AW-1:0] RA_ADDR      = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              beq_eq,
  output logic              rom_rd,
  output logic              stall,
  output logic              flush,
  output logic [REG_AW-1:0] addr_rs,
  output logic [REG_AW-1:0] addr_rt,
  output logic [5:0]        ex_imm,
  output logic [2:0]        ex_shamt,
  output logic [2:0]        ex_alu_cmd,
  output logic              ex_op2_sel,
  output logic              ex_shamt_sel,
  output logic [1:0]        pc_sel,
  output logic              mem_ram_rd,
  output logic              mem_ram_wr,
  output logic              wb_wr,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [1:0]        wb_sel
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES) + 1;

  localparam logic [3:0] OpR    = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpSlti = 4'h3;
  localparam logic [3:0] OpLw   = 4'h4;
  localparam logic [3:0] OpSw   = 4'h5;
  localparam logic [3:0] OpBeq  = 4'h6;
  localparam logic [3:0] OpJ    = 4'h7;
  localparam logic [3:0] OpJal  = 4'h8;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluSll = 3'b010;
  localparam logic [2:0] AluSlt = 3'b011;
  localparam logic [2:0] AluSrl = 3'b100;
  localparam logic [2:0] AluAnd = 3'b101;
  localparam logic [2:0] AluOr  = 3'b110;
  localparam logic [2:0] AluEq  = 3'b111;

  typedef struct packed {
    logic [5:0]        imm;
    logic [2:0]        shamt;
    logic [2:0]        alu_cmd;
    logic              op2_sel;
    logic              shamt_sel;
    logic              is_beq;
    logic              is_j;
    logic              is_jr;
    logic              ram_rd;
    logic              ram_wr;
    logic              wr;
    logic [REG_AW-1:0] waddr;
    logic [1:0]        wb_sel;
  } ctrl_t;

  logic [3:0]        op;
  logic [2:0]        fc;
  logic [REG_AW-1:0] f_rs, f_rt, f_rd;

  assign op   = instr[15:12];
  assign fc   = instr[2:0];
  assign f_rs = REG_AW'(instr[11:9]);
  assign f_rt = REG_AW'(instr[8:6]);
  assign f_rd = REG_AW'(instr[5:3]);

  // run_q marks that the ROM word is live; it stays low until the first edge after reset.
  logic            run_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  ctrl_t           ex_q, ex_d;
  logic            mem_rd_q, mem_wr_q, mem_rf_wr_q;
  logic [REG_AW-1:0] mem_waddr_q;
  logic [1:0]      mem_sel_q;
  logic            wb_wr_q;
  logic [REG_AW-1:0] wb_waddr_q;
  logic [1:0]      wb_sel_q;

  ctrl_t dec;
  logic  rd_rs, rd_rt, is_bubble;

  always_comb begin
    dec       = '0;
    rd_rs     = 1'b0;
    rd_rt     = 1'b0;
    dec.imm   = instr[5:0];
    dec.shamt = instr[5:3];
    case (op)
      OpR: begin
        if (fc == 3'd7) begin
          dec.is_jr = 1'b1;
          rd_rs     = 1'b1;
        end else if (fc == 3'd5 || fc == 3'd6) begin
          dec.alu_cmd   = (fc == 3'd5) ? AluSll : AluSrl;
          dec.op2_sel   = 1'b1;
          dec.shamt_sel = 1'b1;
          dec.wr        = 1'b1;
          dec.waddr     = f_rs;
          rd_rt         = 1'b1;
        end else begin
          dec.wr    = 1'b1;
          dec.waddr = f_rd;
          rd_rs     = 1'b1;
          rd_rt     = 1'b1;
          case (fc)
            3'd0:    dec.alu_cmd = AluAdd;
            3'd1:    dec.alu_cmd = AluSub;
            3'd2:    dec.alu_cmd = AluAnd;
            3'd3:    dec.alu_cmd = AluOr;
            default: dec.alu_cmd = AluSlt;
          endcase
        end
      end
      OpAddi, OpSlti, OpLw: begin
        dec.alu_cmd = (op == OpSlti) ? AluSlt : AluAdd;
        dec.op2_sel = 1'b1;
        dec.wr      = 1'b1;
        dec.waddr   = f_rt;
        rd_rs       = 1'b1;
        if (op == OpLw) begin
          dec.ram_rd = 1'b1;
          dec.wb_sel = 2'd1;
        end
      end
      OpSw: begin
        dec.op2_sel = 1'b1;
        dec.ram_wr  = 1'b1;
        rd_rs       = 1'b1;
        rd_rt       = 1'b1;
      end
      OpBeq: begin
        dec.alu_cmd = AluEq;
        dec.is_beq  = 1'b1;
        rd_rs       = 1'b1;
        rd_rt       = 1'b1;
      end
      OpJ: dec.is_j = 1'b1;
      OpJal: begin
        dec.is_j   = 1'b1;
        dec.wr     = 1'b1;
        dec.waddr  = RA_ADDR;
        dec.wb_sel = 2'd2;
      end
      default: ;
    endcase
    // Anything without an effect, or whose only effect is a write to r0, is a bubble.
    is_bubble = !(dec.wr || dec.ram_wr || dec.is_beq || dec.is_j || dec.is_jr) ||
                (dec.wr && dec.waddr == '0);
    if (is_bubble) begin
      dec   = '0;
      rd_rs = 1'b0;
      rd_rt = 1'b0;
    end
  end

  logic load_use, transfer;

  always_comb begin
    pc_sel = 2'd0;
    if (ex_q.is_jr)                 pc_sel = 2'd3;
    else if (ex_q.is_j)             pc_sel = 2'd2;
    else if (ex_q.is_beq && beq_eq) pc_sel = 2'd1;
  end

  assign transfer = (pc_sel != 2'd0);
  assign load_use = ex_q.ram_rd && ((rd_rs && f_rs == ex_q.waddr) ||
                                    (rd_rt && f_rt == ex_q.waddr));
  assign flush    = transfer || (cnt_q != '0);
  assign stall    = run_q && load_use && !flush;
  assign rom_rd   = run_q && !stall;
  assign addr_rs  = run_q ? f_rs : '0;
  assign addr_rt  = run_q ? f_rt : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (transfer)            cnt_d = CntW'(FLUSH_CYCLES - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
    ex_d = (run_q && !stall && !flush) ? dec : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      ex_q        <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rf_wr_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_sel_q   <= '0;
      wb_wr_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_sel_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      mem_rd_q    <= ex_q.ram_rd;
      mem_wr_q    <= ex_q.ram_wr;
      mem_rf_wr_q <= ex_q.wr;
      mem_waddr_q <= ex_q.waddr;
      mem_sel_q   <= ex_q.wb_sel;
      wb_wr_q     <= mem_rf_wr_q;
      wb_waddr_q  <= mem_waddr_q;
      wb_sel_q    <= mem_sel_q;
    end
  end

  assign ex_imm       = ex_q.imm;
  assign ex_shamt     = ex_q.shamt;
  assign ex_alu_cmd   = ex_q.alu_cmd;
  assign ex_op2_sel   = ex_q.op2_sel;
  assign ex_shamt_sel = ex_q.shamt_sel;
  assign mem_ram_rd   = mem_rd_q;
  assign mem_ram_wr   = mem_wr_q;
  assign wb_wr        = wb_wr_q;
  assign wb_waddr     = wb_waddr_q;
  assign wb_sel       = wb_sel_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboarded bench for pipe_control: expected writebacks and RAM accesses are queued with
// their due cycle when a word is accepted, and popped when the DUT presents them.
module tb_pipe_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        beq_eq;
  logic        rom_rd, stall, flush;
  logic [3:0]  addr_rs, addr_rt;
  logic [5:0]  ex_imm;
  logic [2:0]  ex_shamt, ex_alu_cmd;
  logic        ex_op2_sel, ex_shamt_sel;
  logic [1:0]  pc_sel;
  logic        mem_ram_rd, mem_ram_wr;
  logic        wb_wr;
  logic [3:0]  wb_waddr;
  logic [1:0]  wb_sel;

  pipe_control dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .beq_eq       (beq_eq),
    .rom_rd       (rom_rd),
    .stall        (stall),
    .flush        (flush),
    .addr_rs      (addr_rs),
    .addr_rt      (addr_rt),
    .ex_imm       (ex_imm),
    .ex_shamt     (ex_shamt),
    .ex_alu_cmd   (ex_alu_cmd),
    .ex_op2_sel   (ex_op2_sel),
    .ex_shamt_sel (ex_shamt_sel),
    .pc_sel       (pc_sel),
    .mem_ram_rd   (mem_ram_rd),
    .mem_ram_wr   (mem_ram_wr),
    .wb_wr        (wb_wr),
    .wb_waddr     (wb_waddr),
    .wb_sel       (wb_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [3:0] waddr;
    logic [1:0] sel;
    logic       rrd;
    logic       rwr;
  } exp_t;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  waddr;
    logic [1:0]  sel;
  } wb_ent_t;

  typedef struct packed {
    int unsigned cyc;
    logic        rd;
    logic        wr;
  } ram_ent_t;

  wb_ent_t     wbq[$];
  ram_ent_t    ramq[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_stalls;

  localparam exp_t NONE = '0;
  localparam logic [15:0] NOP = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ewb(input logic [3:0] a, input logic [1:0] s, input logic r);
    exp_t e;
    e       = '0;
    e.wr    = 1'b1;
    e.waddr = a;
    e.sel   = s;
    e.rrd   = r;
    return e;
  endfunction

  function automatic logic [15:0] rtype(input int rs, input int rt, input int rd, input int fc);
    return {4'h0, 3'(rs), 3'(rt), 3'(rd), 3'(fc)};
  endfunction

  function automatic logic [15:0] itype(input int op, input int rs, input int rt, input int imm);
    return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Present one word until the DUT accepts it; queue its expected effects at acceptance.
  task automatic issue(input logic [15:0] w, input exp_t e);
    logic acc;
    logic done;
    instr       = w;
    last_stalls = 0;
    done        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = rom_rd;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
      last_stalls++;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    else begin
      if (e.wr) wbq.push_back('{cyc: cyc + 2, waddr: e.waddr, sel: e.sel});
      if (e.rrd || e.rwr) ramq.push_back('{cyc: cyc + 1, rd: e.rrd, wr: e.rwr});
    end
  endtask

  wb_ent_t  wb_e;
  ram_ent_t ram_e;

  always @(negedge clk) begin
    if (wb_wr) begin
      if (wbq.size() == 0) check("wb_unexpected", {28'd0, wb_waddr}, 32'hFFFF_FFFF);
      else begin
        wb_e = wbq.pop_front();
        check("wb_cycle", cyc, wb_e.cyc);
        check("wb_waddr", {28'd0, wb_waddr}, {28'd0, wb_e.waddr});
        check("wb_sel", {30'd0, wb_sel}, {30'd0, wb_e.sel});
      end
    end
    if (mem_ram_rd || mem_ram_wr) begin
      if (ramq.size() == 0) check("ram_unexpected", {30'd0, mem_ram_rd, mem_ram_wr}, 32'd0);
      else begin
        ram_e = ramq.pop_front();
        check("ram_cycle", cyc, ram_e.cyc);
        check("ram_rd_wr", {30'd0, mem_ram_rd, mem_ram_wr}, {30'd0, ram_e.rd, ram_e.wr});
      end
    end
  end

  logic [2:0]  alu_tab [5] = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b011};
  logic [15:0] w;
  exp_t        sw_e;

  initial begin
    rst    = 1'b1;
    instr  = 16'h0298;
    beq_eq = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_rom_rd", rom_rd, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_addr_rs", addr_rs, 0);
    check("rst_pc_sel", pc_sel, 0);
    check("rst_wb_wr", wb_wr, 0);
    check("rst_ram_rd", mem_ram_rd, 0);
    #20 rst = 1'b1;
    #1 check("rom_rd_pre_edge", rom_rd, 0);
    @(posedge clk);
    #1 check("rom_rd_post_edge", rom_rd, 1);
    check("addr_rs_add", addr_rs, 1);
    check("addr_rt_add", addr_rt, 2);

    issue(16'h0298, ewb(4'd3, 2'd0, 1'b0));
    check("add_alu", ex_alu_cmd, 3'b000);
    check("add_op2", ex_op2_sel, 0);

    for (int f = 0; f < 5; f++) begin
      issue(rtype(1, 2, f + 3, f), ewb(4'(f + 3), 2'd0, 1'b0));
      check("rtype_alu", ex_alu_cmd, alu_tab[f]);
    end

    issue(itype(1, 1, 2, 5), ewb(4'd2, 2'd0, 1'b0));
    check("addi_alu", ex_alu_cmd, 3'b000);
    check("addi_op2", ex_op2_sel, 1);
    check("addi_shsel", ex_shamt_sel, 0);
    check("addi_imm", ex_imm, 5);
    issue(itype(3, 1, 7, 63), ewb(4'd7, 2'd0, 1'b0));
    check("slti_alu", ex_alu_cmd, 3'b011);
    check("slti_imm", ex_imm, 63);

    w = rtype(1, 2, 3, 5);
    instr = w;
    #1 check("sll_addr_rt", addr_rt, 2);
    issue(w, ewb(4'd1, 2'd0, 1'b0));
    check("sll_alu", ex_alu_cmd, 3'b010);
    check("sll_shamt", ex_shamt, 3);
    check("sll_op2", ex_op2_sel, 1);
    check("sll_shsel", ex_shamt_sel, 1);
    issue(rtype(4, 5, 2, 6), ewb(4'd4, 2'd0, 1'b0));
    check("srl_alu", ex_alu_cmd, 3'b100);

    issue(rtype(1, 2, 0, 0), NONE);
    issue(16'hF123, NONE);

    // Load-use through rs, then through sw's data register, then an independent word.
    issue(itype(4, 1, 2, 0), ewb(4'd2, 2'd1, 1'b1));
    w = rtype(2, 1, 3, 0);
    instr = w;
    #1;
    check("lu_stall", stall, 1);
    check("lu_rom_rd", rom_rd, 0);
    check("lu_flush", flush, 0);
    issue(w, ewb(4'd3, 2'd0, 1'b0));
    check("lu_stall_cycles", last_stalls, 1);

    issue(itype(4, 1, 4, 1), ewb(4'd4, 2'd1, 1'b1));
    sw_e     = NONE;
    sw_e.rwr = 1'b1;
    issue(itype(5, 1, 4, 0), sw_e);
    check("lu_sw_stall_cycles", last_stalls, 1);

    issue(itype(4, 1, 4, 1), ewb(4'd4, 2'd1, 1'b1));
    w = rtype(1, 5, 3, 0);
    instr = w;
    #1 check("nodep_stall", stall, 0);
    issue(w, ewb(4'd3, 2'd0, 1'b0));
    check("nodep_stall_cycles", last_stalls, 0);
    issue(NOP, NONE);

    // Taken beq squashes the next two words, including a store.
    issue(itype(6, 1, 2, 3), NONE);
    check("beq_alu", ex_alu_cmd, 3'b111);
    beq_eq = 1'b1;
    w = itype(5, 1, 3, 0);
    instr = w;
    #1;
    check("beq_t_pc_sel", pc_sel, 1);
    check("beq_t_flush", flush, 1);
    check("beq_t_stall", stall, 0);
    check("beq_t_rom_rd", rom_rd, 1);
    issue(w, NONE);
    w = rtype(1, 2, 5, 0);
    instr = w;
    #1;
    check("beq_t_flush2", flush, 1);
    check("beq_t_pc_sel2", pc_sel, 0);
    issue(w, NONE);
    beq_eq = 1'b0;
    w = rtype(1, 2, 6, 0);
    instr = w;
    #1 check("beq_t_flush_end", flush, 0);
    issue(w, ewb(4'd6, 2'd0, 1'b0));

    issue(itype(6, 1, 2, 3), NONE);
    w = rtype(1, 2, 7, 0);
    instr = w;
    #1;
    check("beq_nt_pc_sel", pc_sel, 0);
    check("beq_nt_flush", flush, 0);
    issue(w, ewb(4'd7, 2'd0, 1'b0));

    issue(itype(8, 0, 0, 5), ewb(4'hF, 2'd2, 1'b0));
    check("jal_imm", ex_imm, 5);
    w = rtype(1, 2, 5, 0);
    instr = w;
    #1;
    check("jal_pc_sel", pc_sel, 2);
    check("jal_flush", flush, 1);
    issue(w, NONE);
    issue(rtype(1, 2, 6, 0), NONE);
    issue(rtype(1, 2, 7, 0), ewb(4'd7, 2'd0, 1'b0));

    w = rtype(5, 0, 0, 7);
    instr = w;
    #1 check("jr_addr_rs", addr_rs, 5);
    issue(w, NONE);
    w = rtype(1, 2, 3, 0);
    instr = w;
    #1 check("jr_pc_sel", pc_sel, 3);
    issue(w, NONE);
    issue(rtype(1, 2, 4, 0), NONE);

    issue(itype(7, 0, 0, 9), NONE);
    w = rtype(1, 2, 3, 0);
    instr = w;
    #1 check("j_pc_sel", pc_sel, 2);
    issue(w, NONE);
    issue(w, NONE);
    repeat (3) issue(NOP, NONE);

    // Reset with a load in MEM and an addi in EX: both vanish immediately.
    issue(itype(4, 1, 2, 0), NONE);
    issue(itype(1, 1, 5, 7), NONE);
    #1;
    check("pre_rst_ram_rd", mem_ram_rd, 1);
    check("pre_rst_op2", ex_op2_sel, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ram_rd", mem_ram_rd, 0);
    check("mid_rst_op2", ex_op2_sel, 0);
    check("mid_rst_imm", ex_imm, 0);
    check("mid_rst_rom_rd", rom_rd, 0);
    check("mid_rst_wb_wr", wb_wr, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rel_rom_rd_pre", rom_rd, 0);
    @(posedge clk);
    #1 check("rel_rom_rd_post", rom_rd, 1);
    issue(16'h0298, ewb(4'd3, 2'd0, 1'b0));
    repeat (4) issue(NOP, NONE);
    check("wbq_drained", wbq.size(), 0);
    check("ramq_drained", ramq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
